// File: rtl/nes_serial_reader.sv
// nes_serial_reader
//   Reads one 8-bit frame from an NES controller for each nes_latch pulse.
//   Each bit is sampled after a settle wait that covers the 2-flop
//   synchronizer on nes_data. Between bits, one nes_clk pulse is generated
//   with a high time of HALF cycles and a low time of HALF cycles.
//   If a new latch arrives in the middle of a frame, the frame is aborted
//   and restarted, and overrun pulses.
// Ports
//   clk, reset     system clock; asynchronous active-high reset
//   nes_latch      one-cycle frame-start pulse
//   nes_data       asynchronous serial data from the pad, active-low
//   nes_clk        registered controller shift clock, idle 0
//   buttons        last complete frame, 1 = pressed (bit0 A .. bit7 Right)
//   buttons_valid  one-cycle pulse on the edge that updates buttons
//   pressed_edge   buttons that went 0->1 at the last completed frame
//   busy           high while a frame is in progress (any non-IDLE state)
//   overrun        one-cycle pulse when a frame is aborted by a new latch
module nes_serial_reader #(
    parameter int HALF = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       nes_latch,
    input  logic       nes_data,
    output logic       nes_clk,
    output logic [7:0] buttons,
    output logic       buttons_valid,
    output logic [7:0] pressed_edge,
    output logic       busy,
    output logic       overrun
);
    localparam int SETTLE = 3;
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [3:0] HALF_LAST   = 4'(HALF - 1);

    typedef enum logic [2:0] {IDLE, WAIT, SAMPLE, CLK_HI, CLK_LO, DONE} state_t;

    state_t      state;
    logic [2:0]  idx;
    logic [3:0]  cnt;
    logic [6:0]  shreg;   // bits 0..6; bit 7 goes straight into buttons
    logic [1:0]  sync;
    logic        data_s;
    logic [7:0]  frame;

    // The synchronizer resets to 1, which is the line's "not pressed" level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync <= 2'b11;
        else       sync <= {sync[0], nes_data};
    end

    assign data_s = sync[1];
    assign frame  = {~data_s, shreg};
    assign busy   = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            idx           <= 3'd0;
            cnt           <= 4'd0;
            shreg         <= 7'd0;
            nes_clk       <= 1'b0;
            buttons       <= 8'h00;
            pressed_edge  <= 8'h00;
            buttons_valid <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            buttons_valid <= 1'b0;
            overrun       <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    // A latch that arrives during DONE chains straight into the
                    // next frame. The current frame has already completed, so
                    // this is not an overrun.
                    if (nes_latch) begin
                        state <= WAIT;
                        idx   <= 3'd0;
                        cnt   <= 4'd0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    if (nes_latch) begin
                        // Abort the partial frame. buttons and pressed_edge
                        // are left untouched.
                        state   <= WAIT;
                        idx     <= 3'd0;
                        cnt     <= 4'd0;
                        nes_clk <= 1'b0;
                        overrun <= 1'b1;
                    end else begin
                        case (state)
                            WAIT: begin
                                if (cnt == SETTLE_LAST) begin
                                    state <= SAMPLE;
                                    cnt   <= 4'd0;
                                end else begin
                                    cnt <= cnt + 4'd1;
                                end
                            end
                            SAMPLE: begin
                                if (idx == 3'd7) begin
                                    buttons       <= frame;
                                    pressed_edge  <= frame & ~buttons;
                                    buttons_valid <= 1'b1;
                                    state         <= DONE;
                                end else begin
                                    shreg[idx] <= ~data_s;
                                    nes_clk    <= 1'b1;
                                    cnt        <= 4'd0;
                                    state      <= CLK_HI;
                                end
                            end
                            CLK_HI: begin
                                if (cnt == HALF_LAST) begin
                                    nes_clk <= 1'b0;
                                    cnt     <= 4'd0;
                                    state   <= CLK_LO;
                                end else begin
                                    cnt <= cnt + 4'd1;
                                end
                            end
                            CLK_LO: begin
                                if (cnt == HALF_LAST) begin
                                    idx   <= idx + 3'd1;
                                    cnt   <= 4'd0;
                                    state <= WAIT;
                                end else begin
                                    cnt <= cnt + 4'd1;
                                end
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end
            endcase
        end
    end
endmodule

// File: doc/nes_serial_reader.md
NES_SERIAL_READER -- requirements
Module: nes_serial_reader

Interface
REQ-001 Parameter: HALF, default 1, nes_clk high time and low time in clk cycles (legal range 1..15).
REQ-002 Constant: SETTLE = 3, wait cycles before each data sample (covers 2-flop synchronizer).
REQ-003 clk  input  1  system clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 nes_latch  input  1  one-cycle frame-start pulse from the latch generator; 1 = start frame.
REQ-006 nes_data  input  1  controller serial data, asynchronous, active-low (0 = pressed).
REQ-007 nes_clk  output  1  registered controller shift clock, idle 0.
REQ-008 buttons  output  8  last complete frame, 1 = pressed; bit0 A, bit1 B, bit2 Select, bit3 Start, bit4 Up, bit5 Down, bit6 Left, bit7 Right.
REQ-009 buttons_valid  output  1  one-cycle pulse; buttons updated on the same edge.
REQ-010 pressed_edge  output  8  buttons & ~previous buttons, updated with buttons, held until the next frame completes.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 overrun  output  1  one-cycle pulse: frame aborted by a new nes_latch.

Function
REQ-013 nes_data passes through a 2-flop synchronizer; data_s = nes_data delayed 2 edges.
REQ-014 States: IDLE, WAIT, SAMPLE, CLK_HI, CLK_LO, DONE; 3-bit bit index idx; 4-bit phase counter.
REQ-015 IDLE: nes_latch=1 at an edge -> WAIT, idx=0, counter cleared; otherwise stay.
REQ-016 WAIT: lasts exactly SETTLE cycles, then -> SAMPLE.
REQ-017 SAMPLE: lasts 1 cycle; at its closing edge shift bit idx <= ~data_s.
REQ-018 SAMPLE with idx<7 -> CLK_HI; SAMPLE with idx=7 -> DONE, buttons loaded with all 8 captured bits on that edge.
REQ-019 CLK_HI: nes_clk=1 for HALF cycles -> CLK_LO; CLK_LO: nes_clk=0 for HALF cycles -> WAIT, idx+1.
REQ-020 nes_clk is a registered output: 1 exactly in CLK_HI cycles, 0 otherwise; exactly 7 high pulses per frame.
REQ-021 Timing: latch captured at edge T -> bit k captured at edge T+4+k*(4+2*HALF); buttons/valid at edge T+32+14*HALF (T+46 for HALF=1).
REQ-022 DONE: lasts 1 cycle, buttons_valid=1, -> IDLE, unless nes_latch=1 -> WAIT with no overrun.
REQ-023 pressed_edge = new buttons & ~old buttons, computed and registered on the buttons-update edge.
REQ-024 nes_latch=1 in WAIT, SAMPLE, CLK_HI or CLK_LO: overrun=1 next cycle, restart in WAIT with idx=0, nes_clk=0 next cycle, buttons/pressed_edge unchanged, no valid.
REQ-025 Partial frames never update buttons or pressed_edge.
REQ-026 idx does not wrap: 7 is terminal, always through DONE.

Reset
REQ-027 Reset asserted: state IDLE, idx 0, counter 0, nes_clk 0, buttons 0x00, pressed_edge 0x00, buttons_valid 0, overrun 0, busy 0, synchronizer flops 1.
REQ-028 Reset mid-frame: frame abandoned immediately, no buttons_valid, outputs at reset values.
REQ-029 After reset release, first nes_latch in IDLE starts a frame normally; an overlapping latch is ignored.

Verification
REQ-030 HALF=1, pad model returns A+Start (0x09): latch at T -> 7 nes_clk pulses, buttons=0x09, pressed_edge=0x09, valid at T+46.
REQ-031 Second frame with pad returning 0x0A: buttons=0x0A, pressed_edge=0x02, one valid pulse.
REQ-032 Latch again 20 cycles into a frame -> overrun pulse, nes_clk low, buttons unchanged, valid 46 cycles after the second latch.
REQ-033 Reset 30 cycles into a frame -> all outputs at reset values, no valid; next latch completes normally.
REQ-034 HALF=3, all buttons pressed -> nes_clk high 3 cycles per pulse, buttons=0xFF at T+74.
REQ-035 Latch coincident with DONE -> valid pulses, no overrun, next frame valid 46 cycles later.
